// File: rtl/pc_unit.sv
// Program-counter unit: increment, PC-relative branch, absolute jump, and
// call/return through a circular return-address stack that keeps the newest entries.
module pc_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               STEP         = 4,
  parameter int               OFF_W        = 19,
  parameter int               RAS_DEPTH    = 4,
  localparam int              CNT_W        = $clog2(RAS_DEPTH + 1)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic [OFF_W-1:0] offset,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] PC,
  output logic [CNT_W-1:0] ras_count,
  output logic             ras_overflow,
  output logic             ras_underflow
);

  localparam int               PTR_W  = $clog2(RAS_DEPTH);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  typedef enum logic [2:0] {
    MODE_HOLD     = 3'b000,
    MODE_INC      = 3'b001,
    MODE_BR_REL   = 3'b010,
    MODE_LOAD     = 3'b011,
    MODE_CALL     = 3'b100,
    MODE_RET      = 3'b101,
    MODE_CALL_REL = 3'b110,
    MODE_RSVD     = 3'b111
  } mode_e;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] top_q, top_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];
  logic             ras_we;
  logic [PTR_W-1:0] ras_waddr;
  logic [WIDTH-1:0] ras_wdata;

  logic [WIDTH-1:0] offset_sext;
  logic [PTR_W-1:0] top_inc, top_dec;
  logic             ras_full, ras_empty;

  assign offset_sext = WIDTH'($signed(offset));
  assign top_inc     = (top_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : top_q + 1'b1;
  assign top_dec     = (top_q == '0) ? PTR_W'(RAS_DEPTH - 1) : top_q - 1'b1;
  assign ras_full    = (cnt_q == CNT_W'(RAS_DEPTH));
  assign ras_empty   = (cnt_q == '0);

  // top_q always names the newest entry; when full, top_inc lands on the oldest.
  always_comb begin
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    top_d     = top_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    ras_we    = 1'b0;
    ras_waddr = top_inc;
    ras_wdata = pc_q + STEP_W;

    if (enable) begin
      case (mode_e'(mode))
        MODE_INC:    pc_d = pc_q + STEP_W;
        MODE_BR_REL: pc_d = pc_q + offset_sext;
        MODE_LOAD:   pc_d = target;
        MODE_CALL: begin
          ras_we = 1'b1;
          pc_d   = target;
        end
        MODE_RET: begin
          if (!ras_empty) begin
            pc_d  = ras_mem_q[top_q];
            cnt_d = cnt_q - 1'b1;
            top_d = top_dec;
          end else begin
            pc_d  = pc_q + STEP_W;
            unf_d = 1'b1;
          end
        end
        MODE_CALL_REL: begin
          ras_we = 1'b1;
          pc_d   = pc_q + offset_sext;
        end
        default: ;
      endcase
    end

    if (ras_we) begin
      top_d = top_inc;
      if (ras_full) ovf_d = 1'b1;
      else          cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clock) begin
    if (clear) begin
      pc_q  <= RESET_VECTOR;
      cnt_q <= '0;
      top_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      top_q <= top_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // NOTE: the stack storage is deliberately not reset; ras_count marks which
  // entries are valid, so clearing the array would only cost reset routing.
  always_ff @(posedge clock) begin
    if (ras_we && !clear) ras_mem_q[ras_waddr] <= ras_wdata;
  end

  assign PC            = pc_q;
  assign ras_count     = cnt_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus random commands, checked against a
// queue-based model of the PC and return-address stack.
module tb_pc_unit;

  localparam int WIDTH = 32;
  localparam int OFF_W = 19;
  localparam int DEPTH = 4;
  localparam logic [WIDTH-1:0] RV = 32'h0;

  localparam logic [2:0] M_HOLD = 3'd0, M_INC = 3'd1, M_BR = 3'd2, M_LOAD = 3'd3,
                         M_CALL = 3'd4, M_RET = 3'd5, M_CREL = 3'd6, M_RSVD = 3'd7;

  logic             clock = 1'b0;
  logic             clear = 1'b1;
  logic             enable = 1'b0;
  logic [2:0]       mode = 3'd0;
  logic [OFF_W-1:0] offset = '0;
  logic [WIDTH-1:0] target = '0;
  logic [WIDTH-1:0] PC;
  logic [2:0]       ras_count;
  logic             ras_overflow;
  logic             ras_underflow;

  pc_unit dut (
    .clock        (clock),
    .clear        (clear),
    .enable       (enable),
    .mode         (mode),
    .offset       (offset),
    .target       (target),
    .PC           (PC),
    .ras_count    (ras_count),
    .ras_overflow (ras_overflow),
    .ras_underflow(ras_underflow)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [WIDTH-1:0] m_pc;
  logic [WIDTH-1:0] m_stack[$];
  logic             m_ovf, m_unf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] displacement(input logic [OFF_W-1:0] off);
    longint d;
    d = longint'(off);
    if (d >= (longint'(1) << (OFF_W - 1))) d = d - (longint'(1) << OFF_W);
    return WIDTH'(d);
  endfunction

  task automatic model_push(input logic [WIDTH-1:0] addr);
    if (m_stack.size() == DEPTH) begin
      void'(m_stack.pop_front());
      m_ovf = 1'b1;
    end
    m_stack.push_back(addr);
  endtask

  task automatic model_step(input logic clr, input logic en, input logic [2:0] md,
                            input logic [OFF_W-1:0] off, input logic [WIDTH-1:0] tgt);
    if (clr) begin
      m_pc = RV;
      m_stack.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (en) begin
      case (md)
        M_INC:  m_pc = m_pc + 32'd4;
        M_BR:   m_pc = m_pc + displacement(off);
        M_LOAD: m_pc = tgt;
        M_CALL: begin model_push(m_pc + 32'd4); m_pc = tgt; end
        M_RET:  begin
          if (m_stack.size() > 0) m_pc = m_stack.pop_back();
          else begin m_pc = m_pc + 32'd4; m_unf = 1'b1; end
        end
        M_CREL: begin model_push(m_pc + 32'd4); m_pc = m_pc + displacement(off); end
        default: ;
      endcase
    end
  endtask

  // Drive on the falling edge, let the rising edge execute, compare 1 ns later.
  task automatic cmd(input string tag, input logic clr, input logic en, input logic [2:0] md,
                     input logic [OFF_W-1:0] off, input logic [WIDTH-1:0] tgt);
    @(negedge clock);
    clear  = clr;
    enable = en;
    mode   = md;
    offset = off;
    target = tgt;
    @(posedge clock);
    model_step(clr, en, md, off, tgt);
    #1;
    check({tag, ".pc"},  64'(PC),            64'(m_pc));
    check({tag, ".cnt"}, 64'(ras_count),     64'(m_stack.size()));
    check({tag, ".ovf"}, 64'(ras_overflow),  64'(m_ovf));
    check({tag, ".unf"}, 64'(ras_underflow), 64'(m_unf));
  endtask

  task automatic op(input string tag, input logic [2:0] md,
                    input logic [OFF_W-1:0] off, input logic [WIDTH-1:0] tgt);
    cmd(tag, 1'b0, 1'b1, md, off, tgt);
  endtask

  task automatic do_clear();
    cmd("clear", 1'b1, 1'b0, M_HOLD, '0, '0);
  endtask

  initial begin
    m_pc  = RV;
    m_ovf = 1'b0;
    m_unf = 1'b0;

    // Reset and increment
    do_clear();
    check("rst.pc", 64'(PC), 64'h0);
    op("inc", M_INC, '0, '0);  check("inc1", 64'(PC), 64'd4);
    op("inc", M_INC, '0, '0);  check("inc2", 64'(PC), 64'd8);
    op("inc", M_INC, '0, '0);  check("inc3", 64'(PC), 64'd12);
    cmd("dis", 1'b0, 1'b0, M_INC, '0, '0);
    cmd("dis", 1'b0, 1'b0, M_INC, '0, '0);
    check("hold", 64'(PC), 64'd12);
    op("rsvd", M_RSVD, 19'h00010, 32'h1234);
    check("rsvd", 64'(PC), 64'd12);

    // Relative branches and wrap
    op("ld", M_LOAD, '0, 32'h100);
    op("brn", M_BR, 19'h7FFF0, '0);  check("br_neg", 64'(PC), 64'hF0);
    op("brp", M_BR, 19'h00020, '0);  check("br_pos", 64'(PC), 64'h110);
    op("ld", M_LOAD, '0, 32'hFFFF_FFFC);
    op("wrap", M_INC, '0, '0);       check("wrap", 64'(PC), 64'h0);

    // Nested call/return
    op("ld", M_LOAD, '0, 32'h40);
    op("call", M_CALL, '0, 32'h200);
    op("crel", M_CREL, 19'h10, '0);
    check("nest.pc", 64'(PC), 64'h210);
    check("nest.cnt", 64'(ras_count), 64'd2);
    op("ret1", M_RET, '0, '0);       check("ret1", 64'(PC), 64'h204);
    op("ret2", M_RET, '0, '0);       check("ret2", 64'(PC), 64'h44);
    check("ret.cnt", 64'(ras_count), 64'd0);

    // Overflow: CALLs from A0..A4 where Ai = 0x1000*(i+1)
    op("ld", M_LOAD, '0, 32'h1000);
    for (int i = 1; i <= 5; i++) op("ovcall", M_CALL, '0, 32'(32'h1000 * (i + 1)));
    check("ovf.flag", 64'(ras_overflow), 64'd1);
    check("ovf.cnt", 64'(ras_count), 64'd4);
    for (int i = 4; i >= 1; i--) begin
      op("ovret", M_RET, '0, '0);
      check("ovf.ret", 64'(PC), 64'(32'h1000 * (i + 1) + 32'd4));
    end

    // Underflow
    do_clear();
    op("ld", M_LOAD, '0, 32'h80);
    op("unf", M_RET, '0, '0);
    check("unf.pc", 64'(PC), 64'h84);
    check("unf.flag", 64'(ras_underflow), 64'd1);
    check("unf.cnt", 64'(ras_count), 64'd0);

    // Clear during a call
    op("c1", M_CALL, '0, 32'h300);
    op("c2", M_CALL, '0, 32'h400);
    cmd("cclr", 1'b1, 1'b1, M_CALL, '0, 32'h500);
    check("cclr.pc", 64'(PC), 64'(RV));
    check("cclr.cnt", 64'(ras_count), 64'd0);
    op("cclr.ret", M_RET, '0, '0);
    check("cclr.unf", 64'(ras_underflow), 64'd1);
    check("cclr.unfpc", 64'(PC), 64'(RV + 32'd4));

    // Random commands
    do_clear();
    for (int n = 0; n < 3000; n++) begin
      logic             r_clr, r_en;
      logic [2:0]       r_md;
      logic [OFF_W-1:0] r_off;
      logic [WIDTH-1:0] r_tgt;
      r_clr = ($urandom_range(0, 99) == 0);
      r_en  = ($urandom_range(0, 9) < 8);
      r_md  = 3'($urandom_range(0, 7));
      r_off = OFF_W'($urandom);
      r_tgt = $urandom;
      cmd("rnd", r_clr, r_en, r_md, r_off, r_tgt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
